// File: rtl/pio_cmd_arbiter_if.sv
// Downstream actuator command bus: valid/ready with source channel and payload.
// The master holds chan/data stable while valid is high and ready is low.
interface pio_cmd_arbiter_if #(
  parameter int NCH   = 3,
  parameter int CMD_W = 32
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              cmd_valid_o;
  logic              cmd_ready_i;
  logic [CW-1:0]     cmd_chan_o;
  logic [CMD_W-2:0]  cmd_data_o;

  modport master (
    output cmd_valid_o,
    output cmd_chan_o,
    output cmd_data_o,
    input  cmd_ready_i
  );

  modport slave (
    input  cmd_valid_o,
    input  cmd_chan_o,
    input  cmd_data_o,
    output cmd_ready_i
  );
endinterface

// File: rtl/pio_cmd_arbiter.sv
// Round-robin arbiter of toggle-flagged PIO command channels onto one valid/ready bus.
// Toggle at edge N -> pending N+1 -> valid N+2; holds chan/data under backpressure, 1 cmd/cycle.
module pio_cmd_arbiter #(
  parameter int NCH   = 3,
  parameter int CMD_W = 32
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [NCH*CMD_W-1:0] ch_cmd_i,
  input  logic                 ovf_clr_i,
  pio_cmd_arbiter_if.master    cmd_if,
  output logic [31:0]          status_o
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = CMD_W - 1;

  logic           armed_q;
  logic [NCH-1:0] prev_tog_q;
  logic [NCH-1:0] tog, evt;

  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] tag_q, tag_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [PW-1:0]  pay_q [NCH];
  logic [PW-1:0]  pay_d [NCH];

  logic           out_vld_q, out_vld_d;
  logic [CW-1:0]  out_chan_q, out_chan_d;
  logic [PW-1:0]  out_data_q, out_data_d;
  logic           out_tag_q, out_tag_d;

  logic [CW-1:0]  last_q, last_d;
  logic           seen_q, seen_d;
  logic [31:0]    status_q, status_d;

  logic           gnt;
  logic           accept;
  logic [CW-1:0]  gnt_idx;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tog[i] = ch_cmd_i[i*CMD_W + CMD_W - 1];
      evt[i] = armed_q && (tog[i] != prev_tog_q[i]);
    end
  end

  // Search order starts just after the last granted channel.
  always_comb begin
    int            s;
    logic          found;
    logic [CW-1:0] cand;
    s       = 0;
    found   = 1'b0;
    cand    = '0;
    gnt_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      s = int'(last_q) + k;
      if (s >= NCH) s = s - NCH;
      cand = CW'(s);
      if (!found && pend_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    accept = out_vld_q && cmd_if.cmd_ready_i;
    gnt    = found && (!out_vld_q || cmd_if.cmd_ready_i);
  end

  always_comb begin
    pend_d     = pend_q;
    tag_d      = tag_q;
    pay_d      = pay_q;
    ovf_d      = ovf_clr_i ? '0 : ovf_q;
    ack_d      = ack_q;
    out_vld_d  = out_vld_q;
    out_chan_d = out_chan_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    last_d     = last_q;
    seen_d     = seen_q;

    if (accept) begin
      ack_d[out_chan_q] = out_tag_q;
      out_vld_d         = 1'b0;
    end

    if (gnt) begin
      out_vld_d       = 1'b1;
      out_chan_d      = gnt_idx;
      out_data_d      = pay_q[gnt_idx];
      out_tag_d       = tag_q[gnt_idx];
      pend_d[gnt_idx] = 1'b0;
      last_d          = gnt_idx;
      seen_d          = 1'b1;
    end

    // A new command landing on the channel being granted refills the slot without overflow.
    for (int i = 0; i < NCH; i++) begin
      if (evt[i]) begin
        if (pend_q[i] && !(gnt && (gnt_idx == CW'(i)))) ovf_d[i] = 1'b1;
        pend_d[i] = 1'b1;
        pay_d[i]  = ch_cmd_i[i*CMD_W +: PW];
        tag_d[i]  = tog[i];
      end
    end

    // Last-grant field reads 0 until the first grant, so an idle block reports all zeros.
    status_d                     = '0;
    status_d[NCH-1:0]            = ack_d;
    status_d[2*NCH-1:NCH]        = pend_d;
    status_d[3*NCH-1:2*NCH]      = ovf_d;
    status_d[3*NCH +: CW]        = seen_d ? last_d : '0;
    status_d[3*NCH + CW]         = out_vld_d;
  end

  always_ff @(posedge clk_clk) begin
    prev_tog_q <= tog;
    if (reset_reset) begin
      armed_q    <= 1'b0;
      pend_q     <= '0;
      tag_q      <= '0;
      ovf_q      <= '0;
      ack_q      <= '0;
      for (int i = 0; i < NCH; i++) pay_q[i] <= '0;
      out_vld_q  <= 1'b0;
      out_chan_q <= '0;
      out_data_q <= '0;
      out_tag_q  <= 1'b0;
      last_q     <= CW'(NCH - 1);
      seen_q     <= 1'b0;
      status_q   <= '0;
    end else begin
      armed_q    <= 1'b1;
      pend_q     <= pend_d;
      tag_q      <= tag_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
      pay_q      <= pay_d;
      out_vld_q  <= out_vld_d;
      out_chan_q <= out_chan_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      last_q     <= last_d;
      seen_q     <= seen_d;
      status_q   <= status_d;
    end
  end

  assign cmd_if.cmd_valid_o = out_vld_q;
  assign cmd_if.cmd_chan_o  = out_chan_q;
  assign cmd_if.cmd_data_o  = out_data_q;
  assign status_o           = status_q;
endmodule

// File: tb/tb_pio_cmd_arbiter.sv
// Directed bench for pio_cmd_arbiter (NCH=3, CMD_W=32); expected values are hand-computed.
module tb_pio_cmd_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] ch_cmd = '0;
  logic        ovf_clr = 1'b0;
  logic [31:0] status;
  logic [2:0]  tog = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  pio_cmd_arbiter_if #(.NCH(3), .CMD_W(32)) cif ();

  pio_cmd_arbiter #(.NCH(3), .CMD_W(32)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .ch_cmd_i    (ch_cmd),
    .ovf_clr_i   (ovf_clr),
    .cmd_if      (cif),
    .status_o    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic [30:0] pay);
    tog[ch] = ~tog[ch];
    ch_cmd[ch*32 +: 32] = {tog[ch], pay};
  endtask

  task automatic check_out(input string tag, input logic [1:0] ch, input logic [30:0] d);
    check({tag, ".vld"},  32'(cif.cmd_valid_o), 32'd1);
    check({tag, ".chan"}, 32'(cif.cmd_chan_o),  32'(ch));
    check({tag, ".data"}, 32'(cif.cmd_data_o),  32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    cif.cmd_ready_i = 1'b1;

    // Reset values and the single-command latency
    tick();
    tick();
    check("rst_status", status, 32'h0);
    check("rst_vld",    32'(cif.cmd_valid_o), 32'h0);
    check("rst_chan",   32'(cif.cmd_chan_o),  32'h0);
    check("rst_data",   32'(cif.cmd_data_o),  32'h0);
    rst = 1'b0;
    tick();
    check("arm_status", status, 32'h0);
    send(1, 31'hAB);
    tick();
    check("t1_c1_vld",    32'(cif.cmd_valid_o), 32'h0);
    check("t1_c1_status", status, 32'h010);
    tick();
    check_out("t1_c2", 2'd1, 31'hAB);
    check("t1_c2_status", status, 32'hA00);
    tick();
    check("t1_c3_vld",    32'(cif.cmd_valid_o), 32'h0);
    check("t1_c3_status", status, 32'h202);

    // Toggle bits high through reset: arming must not create events
    tog = '1;
    ch_cmd = {3{32'h8000_0000}};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t2_idle_vld", 32'(cif.cmd_valid_o), 32'h0);
    end
    check("t2_status", status, 32'h0);

    // All channels at once, two rounds
    tog = '0;
    ch_cmd = '0;
    do_reset();
    for (int c = 0; c < 3; c++) send(c, 31'h10 + 31'(c));
    tick();
    check("t3_pend", status, 32'h038);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("t3_r1", 2'(c), 31'h10 + 31'(c));
    end
    tick();
    check("t3_r1_status", status, 32'h407);
    for (int c = 0; c < 3; c++) send(c, 31'h20 + 31'(c));
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("t3_r2", 2'(c), 31'h20 + 31'(c));
    end
    tick();
    check("t3_r2_status", status, 32'h400);

    // Backpressure with overwrite, overflow and clear
    cif.cmd_ready_i = 1'b0;
    send(2, 31'h55);
    tick();
    tick();
    check_out("t4_first", 2'd2, 31'h55);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) send(2, 31'h66);
      if (k == 5) send(2, 31'h77);
      tick();
      check_out("t4_hold", 2'd2, 31'h55);
    end
    check("t4_ovf_status", status, 32'hD20);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_clr_status", status, 32'hC20);
    cif.cmd_ready_i = 1'b1;
    tick();
    check_out("t4_latest", 2'd2, 31'h77);
    check("t4_acc_status", status, 32'hC04);
    tick();
    check("t4_done_status", status, 32'h404);

    // New command on a channel in the same cycle it is granted
    send(0, 31'h31);
    tick();
    check("t5_pend_status", status, 32'h40C);
    send(0, 31'h32);
    tick();
    check_out("t5_first", 2'd0, 31'h31);
    check("t5_same_status", status, 32'h80C);
    tick();
    check_out("t5_second", 2'd0, 31'h32);
    check("t5_second_status", status, 32'h805);
    tick();
    check("t5_done_vld",    32'(cif.cmd_valid_o), 32'h0);
    check("t5_done_status", status, 32'h004);

    // Reset with an output held and a command pending
    cif.cmd_ready_i = 1'b0;
    send(1, 31'h41);
    tick();
    tick();
    send(2, 31'h42);
    tick();
    check_out("t6_held", 2'd1, 31'h41);
    rst = 1'b1;
    tick();
    check("t6_rst_vld",    32'(cif.cmd_valid_o), 32'h0);
    check("t6_rst_status", status, 32'h0);
    tick();
    rst = 1'b0;
    cif.cmd_ready_i = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t6_post_vld", 32'(cif.cmd_valid_o), 32'h0);
    end
    check("t6_post_status", status, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
